// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the pipelined ALU: op-code encodings
//               and the bit positions of the status flags inside flags[3:0].
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef logic [2:0] alu_op_t;

    // Codes 000..011 keep their legacy meaning from the 4-op ALU.
    localparam alu_op_t ALU_ADD  = 3'b000;
    localparam alu_op_t ALU_AND  = 3'b001;
    localparam alu_op_t ALU_NAND = 3'b010;
    localparam alu_op_t ALU_NOR  = 3'b011;
    localparam alu_op_t ALU_SUB  = 3'b100;
    localparam alu_op_t ALU_XOR  = 3'b101;
    localparam alu_op_t ALU_SHL  = 3'b110;
    localparam alu_op_t ALU_SHR  = 3'b111;

    // flags = {C, V, N, Z}
    localparam int FLG_Z   = 0;
    localparam int FLG_N   = 1;
    localparam int FLG_V   = 2;
    localparam int FLG_C   = 3;
    localparam int FLAGS_W = 4;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Purely combinational WIDTH-bit ALU with status flags.
//               Eight ops; arithmetic is modulo 2^WIDTH.
// Ports       : op     in   3      op code (alu_pkg::ALU_*)
//               a      in   WIDTH  A operand
//               b      in   WIDTH  B operand / shift amount
//               result out  WIDTH  op result
//               flags  out  4      {C,V,N,Z}
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 18
) (
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   result,
    output logic [FLAGS_W-1:0] flags
);

    localparam int              SHAMT_W = $clog2(WIDTH);
    localparam int              c_msb   = WIDTH - 1;
    localparam logic [WIDTH-1:0] c_width = WIDTH'(WIDTH);

    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_diff;
    logic [SHAMT_W-1:0]   w_shamt;
    logic                 w_shift_oob;
    logic [WIDTH-1:0]     w_res;
    logic                 w_c;
    logic                 w_v;

    // One extra bit captures ADD carry-out / SUB borrow directly.
    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};

    // The full B is compared so e.g. B=0x20000 is treated as out of range,
    // not as a shift by its low bits.
    assign w_shamt     = b[SHAMT_W-1:0];
    assign w_shift_oob = (b >= c_width);

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (op)
            ALU_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (a[c_msb] == b[c_msb]) && (w_sum[c_msb] != a[c_msb]);
            end
            ALU_AND:  w_res = a & b;
            ALU_NAND: w_res = ~(a & b);
            ALU_NOR:  w_res = ~(a | b);
            ALU_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_c   = w_diff[WIDTH];
                w_v   = (a[c_msb] != b[c_msb]) && (w_diff[c_msb] != a[c_msb]);
            end
            ALU_XOR:  w_res = a ^ b;
            ALU_SHL:  w_res = w_shift_oob ? '0 : (a << w_shamt);
            ALU_SHR:  w_res = w_shift_oob ? '0 : (a >> w_shamt);
            default:  w_res = '0;
        endcase
    end

    always_comb begin
        flags        = '0;
        flags[FLG_Z] = (w_res == '0);
        flags[FLG_N] = w_res[c_msb];
        flags[FLG_V] = w_v;
        flags[FLG_C] = w_c;
    end

    assign result = w_res;

endmodule : alu_core
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe
// Description : Two-stage pipelined ALU with valid/ready handshake,
//               backpressure, global stall and an accumulator operand.
//               S1 registers the operand bundle, S2 registers result/flags.
// Ports       : clk        in   1      rising-edge clock
//               reset      in   1      asynchronous, active-low
//               enable     in   1      0 = freeze both stages
//               in_valid   in   1      operand bundle valid
//               in_ready   out  1      bundle accepted this cycle
//               alu_select in   3      op code
//               use_acc    in   1      replace A by accumulator at execute
//               clear_acc  in   1      accumulator clear
//               operand1   in   WIDTH  A operand
//               operand2   in   WIDTH  B operand / shift amount
//               out_valid  out  1      result/flags valid
//               out_ready  in   1      downstream accepts result
//               result     out  WIDTH  registered result
//               flags      out  4      {C,V,N,Z}, registered with result
// Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 18
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         alu_select,
    input  logic               use_acc,
    input  logic               clear_acc,
    input  logic [WIDTH-1:0]   operand1,
    input  logic [WIDTH-1:0]   operand2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [FLAGS_W-1:0] flags
);

    // S1 (input stage)
    logic               r_s1_valid;
    alu_op_t            r_s1_op;
    logic               r_s1_use_acc;
    logic [WIDTH-1:0]   r_s1_a;
    logic [WIDTH-1:0]   r_s1_b;

    // S2 (result stage) and accumulator
    logic               r_s2_valid;
    logic [WIDTH-1:0]   r_result;
    logic [FLAGS_W-1:0] r_flags;
    logic [WIDTH-1:0]   r_acc;

    logic               w_advance;
    logic               w_accept;
    logic               w_drain;
    logic [WIDTH-1:0]   w_exec_a;
    logic [WIDTH-1:0]   w_core_result;
    logic [FLAGS_W-1:0] w_core_flags;

    // S1 -> S2 transfer: S2 is free or is being emptied this cycle.
    assign w_advance = enable && r_s1_valid && (!r_s2_valid || out_ready);

    // Gated by reset so nothing is offered while the block is held in reset.
    assign in_ready  = reset && enable && (!r_s1_valid || w_advance);
    assign w_accept  = in_valid && in_ready;

    // S2 empties only when its result is taken and nothing replaces it.
    assign w_drain   = enable && r_s2_valid && out_ready && !w_advance;

    // A same-cycle clear is visible to the accumulator read.
    always_comb begin
        w_exec_a = r_s1_a;
        if (r_s1_use_acc) begin
            w_exec_a = clear_acc ? '0 : r_acc;
        end
    end

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .op     (r_s1_op),
        .a      (w_exec_a),
        .b      (r_s1_b),
        .result (w_core_result),
        .flags  (w_core_flags)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid   <= 1'b0;
            r_s1_op      <= ALU_ADD;
            r_s1_use_acc <= 1'b0;
            r_s1_a       <= '0;
            r_s1_b       <= '0;
        end else if (w_accept) begin
            r_s1_valid   <= 1'b1;
            r_s1_op      <= alu_select;
            r_s1_use_acc <= use_acc;
            r_s1_a       <= operand1;
            r_s1_b       <= operand2;
        end else if (w_advance) begin
            r_s1_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_flags    <= '0;
        end else if (w_advance) begin
            r_s2_valid <= 1'b1;
            r_result   <= w_core_result;
            r_flags    <= w_core_flags;
        end else if (w_drain) begin
            r_s2_valid <= 1'b0;
        end
    end

    // The new result takes priority over a coincident clear so dependent
    // ops keep chaining.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc <= '0;
        end else if (w_advance) begin
            r_acc <= w_core_result;
        end else if (enable && clear_acc) begin
            r_acc <= '0;
        end
    end

    assign out_valid = r_s2_valid;
    assign result    = r_result;
    assign flags     = r_flags;

endmodule : alu_pipe
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_pipe
// Description : Self-checking bench for alu_pipe (WIDTH=18 and WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int W  = 18;
    localparam int NV = 15;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic [3:0]   f;
    } vec_t;

    typedef struct {
        logic [W-1:0] r;
        logic [3:0]   f;
    } exp_t;

    logic clk = 1'b0;
    logic reset, enable, in_valid, in_ready, use_acc, clear_acc;
    logic out_valid, out_ready;
    logic [2:0]   alu_select;
    logic [W-1:0] operand1, operand2, result;
    logic [3:0]   flags;

    logic       e_enable, e_in_valid, e_in_ready, e_use_acc, e_clear_acc;
    logic       e_out_valid, e_out_ready;
    logic [2:0] e_sel;
    logic [7:0] e_a, e_b, e_result;
    logic [3:0] e_flags;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
        .in_ready(in_ready), .alu_select(alu_select), .use_acc(use_acc),
        .clear_acc(clear_acc), .operand1(operand1), .operand2(operand2),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flags(flags)
    );

    alu_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .enable(e_enable), .in_valid(e_in_valid),
        .in_ready(e_in_ready), .alu_select(e_sel), .use_acc(e_use_acc),
        .clear_acc(e_clear_acc), .operand1(e_a), .operand2(e_b),
        .out_valid(e_out_valid), .out_ready(e_out_ready), .result(e_result),
        .flags(e_flags)
    );

    int     n_cmp = 0;
    int     n_bad = 0;
    int     n_pop = 0;
    exp_t   sb[$];
    longint acc_m;
    bit     sb_on;
    bit     hold_pending;
    logic [W-1:0] held_r;
    logic [3:0]   held_f;
    logic         last_fin, last_fout, last_ov, last_ir;
    logic [W-1:0] last_res;
    logic [3:0]   last_flg;
    vec_t   tbl [NV];
    vec_t   tbl8 [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain modular/signed integer arithmetic.
    function automatic void ref_alu(input int op, input longint a, input longint b, input int w,
                                    output longint r, output logic [3:0] f);
        longint m, h, sa, sb2, s;
        logic   c, v;
        m   = (longint'(1) << w) - 1;
        h   = longint'(1) << (w - 1);
        sa  = (a >= h) ? a - (m + 1) : a;
        sb2 = (b >= h) ? b - (m + 1) : b;
        c = 1'b0; v = 1'b0; r = 0;
        case (op)
            0: begin s = a + b; r = s & m; c = (s > m); v = (sa + sb2 > h - 1) || (sa + sb2 < -h); end
            1: r = a & b;
            2: r = ~(a & b) & m;
            3: r = ~(a | b) & m;
            4: begin r = (a - b) & m; c = (a < b); v = (sa - sb2 > h - 1) || (sa - sb2 < -h); end
            5: r = a ^ b;
            6: r = (b >= w) ? 0 : ((a << b) & m);
            7: r = (b >= w) ? 0 : (a >> b);
            default: r = 0;
        endcase
        f = {c, v, (r >= h), (r == 0)};
    endfunction

    // One clock: sample at negedge, check, update scoreboard, step to posedge+1.
    task automatic cyc();
        exp_t         e;
        longint       a_eff, r;
        logic [3:0]   f;
        @(negedge clk);
        last_ir   = in_ready;
        last_ov   = out_valid;
        last_res  = result;
        last_flg  = flags;
        last_fin  = in_valid && in_ready;
        last_fout = out_valid && out_ready && enable;
        if (!enable || !reset) chk("stall_in_ready", 64'(in_ready), 64'd0);
        if (hold_pending) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_result", 64'(result), 64'(held_r));
            chk("hold_flags", 64'(flags), 64'(held_f));
        end
        if (last_fout && sb_on) begin
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL sb_spurious: got result 0x%0h, expected no output", result);
            end else begin
                e = sb.pop_front();
                chk("sb_result", 64'(result), 64'(e.r));
                chk("sb_flags", 64'(flags), 64'(e.f));
                n_pop++;
            end
        end
        if (last_fin && sb_on) begin
            if (use_acc) a_eff = acc_m;
            else         a_eff = longint'(operand1);
            ref_alu(int'(alu_select), a_eff, longint'(operand2), W, r, f);
            acc_m = r;
            e.r = W'(r);
            e.f = f;
            sb.push_back(e);
        end
        hold_pending = out_valid && !last_fout;
        held_r = result;
        held_f = flags;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        enable    = 1'b1;
        for (int i = 0; i < 60 && sb.size() != 0; i++) cyc();
        chk("drain_empty", 64'(sb.size()), 64'd0);
        cyc();
        chk("drain_idle", 64'(last_ov), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int     idx, p0, acc_cnt;
        logic [W-1:0] pre;
        int a_ov [5] = '{0, 0, 1, 1, 1};
        int a_r  [5] = '{0, 0, 1, 2, 3};
        int b_ov [6] = '{0, 0, 1, 1, 1, 1};
        int b_r  [6] = '{0, 0, 4, 5, 1, 2};

        tbl[0]  = '{ALU_ADD,  18'h000CC, 18'h000AA, 18'h00176, 4'b0000};
        tbl[1]  = '{ALU_AND,  18'h000CC, 18'h000AA, 18'h00088, 4'b0000};
        tbl[2]  = '{ALU_NAND, 18'h000CC, 18'h000AA, 18'h3FF77, 4'b0010};
        tbl[3]  = '{ALU_NOR,  18'h000CC, 18'h000AA, 18'h3FF11, 4'b0010};
        tbl[4]  = '{ALU_XOR,  18'h000CC, 18'h000AA, 18'h00066, 4'b0000};
        tbl[5]  = '{ALU_ADD,  18'h3FFFF, 18'h00001, 18'h00000, 4'b1001};
        tbl[6]  = '{ALU_ADD,  18'h1FFFF, 18'h00001, 18'h20000, 4'b0110};
        tbl[7]  = '{ALU_SUB,  18'h00005, 18'h00007, 18'h3FFFE, 4'b1010};
        tbl[8]  = '{ALU_SUB,  18'h20000, 18'h00001, 18'h1FFFF, 4'b0100};
        tbl[9]  = '{ALU_SHL,  18'h00001, 18'h00012, 18'h00000, 4'b0001};
        tbl[10] = '{ALU_SHR,  18'h20000, 18'h00011, 18'h00001, 4'b0000};
        tbl[11] = '{ALU_SHL,  18'h00003, 18'h00011, 18'h20000, 4'b0010};
        tbl[12] = '{ALU_SHR,  18'h3FFFF, 18'h20000, 18'h00000, 4'b0001};
        tbl[13] = '{ALU_SUB,  18'h00007, 18'h00007, 18'h00000, 4'b0001};
        tbl[14] = '{ALU_SHL,  18'h00001, 18'h00021, 18'h00000, 4'b0001};

        tbl8[0] = '{ALU_NAND, 18'h000CC, 18'h000AA, 18'h00077, 4'b0000};
        tbl8[1] = '{ALU_ADD,  18'h000FF, 18'h00001, 18'h00000, 4'b1001};
        tbl8[2] = '{ALU_SHL,  18'h00001, 18'h00008, 18'h00000, 4'b0001};
        tbl8[3] = '{ALU_SUB,  18'h00080, 18'h00001, 18'h0007F, 4'b0100};
        tbl8[4] = '{ALU_SHR,  18'h00080, 18'h00007, 18'h00001, 4'b0000};

        reset = 1'b0; enable = 1'b1; in_valid = 1'b0; use_acc = 1'b0; clear_acc = 1'b0;
        out_ready = 1'b1; alu_select = '0; operand1 = '0; operand2 = '0;
        e_enable = 1'b1; e_in_valid = 1'b0; e_use_acc = 1'b0; e_clear_acc = 1'b0;
        e_out_ready = 1'b1; e_sel = '0; e_a = '0; e_b = '0;
        sb_on = 1'b1; acc_m = 0; hold_pending = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Table: legacy ops, new ops, flags, shift boundaries, 2-cycle latency
        for (int i = 0; i < NV; i++) begin
            alu_select = tbl[i].op; operand1 = tbl[i].a; operand2 = tbl[i].b;
            in_valid = 1'b1;
            cyc();
            chk($sformatf("tbl%0d_accept", i), 64'(last_fin), 64'd1);
            in_valid = 1'b0;
            cyc();
            chk($sformatf("tbl%0d_early", i), 64'(last_ov), 64'd0);
            cyc();
            chk($sformatf("tbl%0d_valid", i), 64'(last_ov), 64'd1);
            chk($sformatf("tbl%0d_result", i), 64'(last_res), 64'(tbl[i].r));
            chk($sformatf("tbl%0d_flags", i), 64'(last_flg), 64'(tbl[i].f));
        end

        // Backpressure: 4 ops offered, only 2 fit while out_ready=0
        out_ready = 1'b0; idx = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = (idx < 4); alu_select = 3'(idx);
            operand1 = W'(18'h100 * (idx + 1)); operand2 = W'(idx + 3);
            cyc();
            if (last_fin) idx++;
        end
        chk("bp_accepted", 64'(idx), 64'd2);
        chk("bp_in_ready", 64'(last_ir), 64'd0);
        out_ready = 1'b1; p0 = n_pop;
        for (int c = 0; c < 20 && (idx < 4 || sb.size() != 0); c++) begin
            in_valid = (idx < 4); alu_select = 3'(idx);
            operand1 = W'(18'h100 * (idx + 1)); operand2 = W'(idx + 3);
            cyc();
            if (last_fin) idx++;
        end
        chk("bp_delivered", 64'(n_pop - p0), 64'd4);
        drain();

        // Accumulator chaining and clear
        sb_on = 1'b0;
        clear_acc = 1'b1; cyc(); clear_acc = 1'b0;
        alu_select = ALU_ADD; use_acc = 1'b1; operand1 = 18'h3ABC; operand2 = 18'd1;
        for (int j = 0; j < 5; j++) begin
            in_valid = (j < 3);
            cyc();
            chk($sformatf("accA_valid%0d", j), 64'(last_ov), 64'(a_ov[j]));
            if (a_ov[j] != 0) chk($sformatf("accA_result%0d", j), 64'(last_res), 64'(a_r[j]));
        end
        for (int j = 0; j < 6; j++) begin
            in_valid = (j < 4); clear_acc = (j == 3);
            cyc();
            chk($sformatf("accB_valid%0d", j), 64'(last_ov), 64'(b_ov[j]));
            if (b_ov[j] != 0) chk($sformatf("accB_result%0d", j), 64'(last_res), 64'(b_r[j]));
        end
        clear_acc = 1'b0; use_acc = 1'b0; in_valid = 1'b0;
        sb_on = 1'b1; acc_m = 2;

        // Reset mid-operation with S1 and S2 full
        out_ready = 1'b0; in_valid = 1'b1; alu_select = ALU_XOR;
        operand1 = 18'd5; operand2 = 18'd3; cyc();
        operand1 = 18'd9; cyc();
        in_valid = 1'b0;
        chk("t5_pre_valid", 64'(out_valid), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        chk("t5_result", 64'(result), 64'd0);
        chk("t5_flags", 64'(flags), 64'd0);
        chk("t5_in_ready", 64'(in_ready), 64'd0);
        sb.delete(); acc_m = 0; hold_pending = 1'b0;
        @(posedge clk); #1;
        chk("t5_in_ready_held", 64'(in_ready), 64'd0);
        reset = 1'b1;
        #1;
        chk("t5_ready_after", 64'(in_ready), 64'd1);
        out_ready = 1'b1; in_valid = 1'b1; alu_select = ALU_ADD; use_acc = 1'b1;
        operand1 = 18'h777; operand2 = 18'd5;
        cyc();
        in_valid = 1'b0; use_acc = 1'b0;
        cyc(); cyc();
        chk("t5_acc_valid", 64'(last_ov), 64'd1);
        chk("t5_acc_result", 64'(last_res), 64'd5);

        // Randomized traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            enable     = ($urandom % 8) != 0;
            in_valid   = $urandom % 2;
            out_ready  = ($urandom % 10) < 7;
            alu_select = 3'($urandom % 8);
            operand1   = W'($urandom);
            operand2   = (($urandom % 3) == 0) ? W'($urandom % 24) : W'($urandom);
            use_acc    = ($urandom % 4) == 0;
            cyc();
        end
        use_acc = 1'b0;
        drain();

        // Stall mid-stream
        enable = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            alu_select = 3'($urandom % 8); operand1 = W'($urandom); operand2 = W'($urandom % 20);
            cyc();
        end
        enable = 1'b0; acc_cnt = 0;
        cyc(); pre = last_res;
        if (last_fin) acc_cnt++;
        chk("stall_valid_held", 64'(last_ov), 64'd1);
        cyc(); if (last_fin) acc_cnt++;
        cyc(); if (last_fin) acc_cnt++;
        chk("stall_no_accepts", 64'(acc_cnt), 64'd0);
        chk("stall_frozen_result", 64'(last_res), 64'(pre));
        enable = 1'b1;
        drain();

        // WIDTH=8 instance
        for (int i = 0; i < 5; i++) begin
            e_sel = tbl8[i].op; e_a = tbl8[i].a[7:0]; e_b = tbl8[i].b[7:0];
            e_in_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("w8_%0d_ready", i), 64'(e_in_ready), 64'd1);
            @(posedge clk); #1;
            e_in_valid = 1'b0;
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("w8_%0d_valid", i), 64'(e_out_valid), 64'd1);
            chk($sformatf("w8_%0d_result", i), 64'(e_result), 64'(tbl8[i].r[7:0]));
            chk($sformatf("w8_%0d_flags", i), 64'(e_flags), 64'(tbl8[i].f));
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_alu_pipe
`default_nettype wire
